// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter that responds on the CPU data bus.
//
// The CPU pushes bytes into a small circular TX FIFO. A serial FSM sends them LSB first
// as 8N1 frames, or as 8E1 frames when UART_TX_PARITY_EN is defined. Queued frames go
// out back to back with no idle gap between them.
//
// Register window (16 bytes at BASE_ADDR, word offset data_addr[3:2]):
//   0 DATA   write pushes data_wr[7:0]; reads 0
//   1 STATUS bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky, write 1 to clear),
//            bit4 parity enabled, bits[15:8] FIFO count
//   2 DIV    bits[15:0] R/W; one bit lasts DIV+1 clk cycles
//   3        reserved; reads 0, writes are ignored
//
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between the data
// bits and the stop bit.
//
// Ports:
//   clk         system clock
//   resetn      synchronous active-low reset
//   data_addr   CPU data address
//   data_wr     CPU write data
//   data_wr_en  CPU byte write enables; any nonzero value is a write cycle
//   sel         combinational window decode
//   data_rd     combinational read data; 0 when sel is low
//   tx          registered serial line; idles high
module uart_tx_periph #(
    parameter logic [31:0] BASE_ADDR   = 32'h20000010,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd24
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr,
    input  logic [3:0]  data_wr_en,
    output logic        sel,
    output logic [31:0] data_rd,
    output logic        tx
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StStop   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] StParity = 3'd3;
    localparam logic       ParityEn = 1'b1;
`else
    localparam logic       ParityEn = 1'b0;
`endif

    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [7:0]      fifo_d [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     div_q, div_d;
    logic [2:0]      state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [15:0]     timer_q, timer_d;
    logic [15:0]     reload_q, reload_d;
    logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic       wr_cycle;
    logic [1:0] offset;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       start_frame;
    logic       full;
    logic       empty;
    logic       busy;
    logic       bit_done;
    logic [7:0] count_byte;
    logic       unused_bits;

    assign sel        = data_addr[31:4] == BASE_ADDR[31:4];
    assign offset     = data_addr[3:2];
    assign wr_cycle   = sel && (data_wr_en != 4'd0);
    assign push_req   = wr_cycle && (offset == 2'd0);
    assign full       = count_q == FullCount;
    assign empty      = count_q == '0;
    assign busy       = state_q != StIdle;
    assign bit_done   = timer_q == 16'd0;
    assign count_byte = 8'(count_q);
    assign tx         = tx_q;

    // Byte lanes and address bits that no register decodes.
    assign unused_bits = ^{data_addr[1:0], data_wr[31:16]};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        timer_d     = timer_q;
        reload_d    = reload_q;
        tx_d        = tx_q;
        start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        // Every active bit reloads the period latched at frame start.
        if (state_q != StIdle) begin
            timer_d = bit_done ? reload_q : timer_q - 16'd1;
        end

        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!empty) begin
                    start_frame = 1'b1;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            StData: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_done) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        if (start_frame) begin
            state_d  = StStart;
            shift_d  = fifo_q[rd_ptr_q];
            reload_d = div_q;
            timer_d  = div_q;
            tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_q[rd_ptr_q];
`endif
        end
    end

    assign pop = start_frame;

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        div_d      = div_q;

        // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
        push_ok = push_req && (!full || pop);

        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (push_ok) begin
            fifo_d[wr_ptr_q] = data_wr[7:0];
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (wr_cycle) begin
            case (offset)
                2'd1: begin
                    if (data_wr[3]) begin
                        overflow_d = 1'b0;
                    end
                end
                2'd2:    div_d = data_wr[15:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        data_rd = 32'd0;
        if (sel) begin
            case (offset)
                2'd1: data_rd = {16'd0, count_byte, 3'd0, ParityEn, overflow_q, busy, empty, full};
                2'd2: data_rd = {16'd0, div_q};
                default: data_rd = 32'd0;
            endcase
        end
    end

    // FIFO storage needs no reset; the pointers and count define its valid contents.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            div_q      <= DEFAULT_DIV;
            state_q    <= StIdle;
            shift_q    <= 8'd0;
            bit_idx_q  <= 3'd0;
            timer_q    <= 16'd0;
            reload_q   <= 16'd0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            div_q      <= div_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            timer_q    <= timer_d;
            reload_q   <= reload_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter on the CPU data bus; the CPU is the initiator and this block is the responder.
- Sits beside the RAM, ROM and LED decode in the SoC top.
- CPU writes bytes into a small TX FIFO, and a serial FSM shifts them out 8N1, LSB first.
- Status and baud divisor are readable and writable over the same bus.

Parameters:
- BASE_ADDR, 32'h20000010: base of the 16-byte register window; bits [3:0] must be 0.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, 2..64.
- DEFAULT_DIV, 16'd24: reset value of DIV; bit period = DIV+1 clk cycles.

Ports:
- clk  in  1  system clock (the divided SoC clock)
- resetn  in  1  synchronous active-low reset
- data_addr  in  32  CPU data address
- data_wr  in  32  CPU write data
- data_wr_en  in  4  CPU byte write enables; nonzero = write cycle
- sel  out  1  combinational; 1 when data_addr[31:4]==BASE_ADDR[31:4]
- data_rd  out  32  combinational read data; 0 when sel=0
- tx  out  1  serial line, idle high (registered)

Behaviour:
- Register map, word offset data_addr[3:2]:
  - 0 DATA: write pushes data_wr[7:0]; reads 0.
  - 1 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[15:8] FIFO count, all others 0. Writing 1 to bit3 clears overflow; other bits ignore writes.
  - 2 DIV: bits[15:0] R/W, upper bits read 0.
  - 3: reserved; reads 0, writes ignored.
- Writes:
  - A write occurs on posedge clk when sel=1 and data_wr_en!=0. data_wr_en=4'b1111 is not required.
  - Writes with sel=0 are ignored.
- Reset (resetn=0 at a posedge, takes effect at that edge):
  - tx=1, FIFO emptied, count=0, overflow=0, DIV=DEFAULT_DIV, FSM=IDLE.
  - Reset mid-frame abandons the frame; tx is high after that edge.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH; separate count register 0..FIFO_DEPTH.
  - Push while full and no pop in the same cycle: byte dropped, overflow set to 1.
  - Push and pop in the same cycle: both performed; count unchanged. This holds when full as well, so no overflow.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the optional feature).
  - IDLE: tx=1. If FIFO is non-empty at a posedge, at that edge: pop the head byte into the shift register, latch DIV into the bit timer reload, go to START, tx<=0.
  - DIV changes take effect only at the next frame start.
  - Bit timer:
    - Loads the latched DIV on entering each bit, decrements every cycle, and advances the state when it is 0.
    - Each bit therefore lasts exactly DIV+1 cycles; DIV=0 gives 1-cycle bits.
  - START -> DATA: tx=shift[0]. The 3-bit bit index runs 0..7; each bit advance shifts right.
  - DATA after bit 7 -> STOP: tx=1 for one bit period.
  - STOP end -> IDLE if the FIFO is empty. Otherwise pop immediately and go to START on the same edge, so frames are back-to-back with no idle gap.
- Latency:
  - DATA write at edge N makes count=1 after N.
  - Pop and tx=0 occur at edge N+1.
  - Total frame length = 10*(DIV+1) cycles.
- busy: 1 from the START entry edge through the STOP exit edge into IDLE.
- Read data and sel depend only on current registers and data_addr, with no read side effects.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - Adds a PARITY state between DATA and STOP, one bit period long.
  - tx = even parity (XOR of the 8 data bits).
  - Frame length = 11*(DIV+1).
  - STATUS bit4 reads 1.
- When undefined:
  - No PARITY state; 8N1 framing.
  - STATUS bit4 reads 0.

Test Plan:
- Reset with resetn=0 for 2 cycles:
  - tx=1.
  - STATUS read at BASE+4 = 32'h00000002 (empty).
  - DIV read at BASE+8 = 32'h00000018.
- Write DIV=3, then DATA=8'h55:
  - tx falls one cycle after the DATA write edge.
  - Start bit lasts 4 cycles; data bits 1,0,1,0,1,0,1,0 follow at 4 cycles each; stop high.
  - busy deasserts 40 cycles after the frame start.
- With DIV=0, write 9 bytes 0x01..0x09 on consecutive cycles:
  - First byte is popped as the second is pushed, so the 9th write fills the FIFO to count=8; STATUS full=1, overflow=0.
  - Write a 10th byte (0xAA) while the FIFO is still full: overflow=1 and 0xAA is never transmitted.
  - Write 32'h8 to STATUS: overflow=0.
- Two bytes queued (0xA5, 0x3C):
  - Second frame's start bit begins on the same edge the first stop bit ends (zero gap).
  - Decoded bytes are 0xA5 then 0x3C.
- Mid-frame reset: during the DATA bits of 0xFF with 3 more bytes queued, assert resetn=0 for one edge:
  - tx=1 after that edge.
  - count=0, and no further frames are sent.
- Decode checks:
  - Access to BASE+12 and to BASE+16: data_rd=0; sel=1 and 0 respectively.
  - Write DIV=7 mid-frame: the current frame keeps the old period; the next frame uses 8 cycles per bit.
  - With UART_TX_PARITY_EN, byte 0x07 yields parity bit 1.
